// File: rtl/jstk_poll_scheduler_if.sv
// Host/SPI-side signal bundle for the PmodJSTK2 poll scheduler.
// master = scheduler, slave = the SPI master plus host logic around it.
interface jstk_poll_scheduler_if #(
    parameter int DATA_W = 40
);
    logic              EN;
    logic              CMD_VALID;
    logic              CMD_READY;
    logic              SPI_BUSY;
    logic              SPI_DONE;
    logic [DATA_W-1:0] SPI_RX;
    logic              SPI_START;
    logic              SPI_SEL;
    logic [DATA_W-1:0] DATA_OUT;
    logic              DATA_VALID;
    logic              TIMEOUT_ERR;
    logic [7:0]        OVERRUN_CNT;
    logic              ERR_CLR;

    modport master (
        input  EN, CMD_VALID, SPI_BUSY, SPI_DONE, SPI_RX, ERR_CLR,
        output CMD_READY, SPI_START, SPI_SEL, DATA_OUT, DATA_VALID, TIMEOUT_ERR, OVERRUN_CNT
    );

    modport slave (
        output EN, CMD_VALID, SPI_BUSY, SPI_DONE, SPI_RX, ERR_CLR,
        input  CMD_READY, SPI_START, SPI_SEL, DATA_OUT, DATA_VALID, TIMEOUT_ERR, OVERRUN_CNT
    );
endinterface

// File: rtl/jstk_poll_scheduler.sv
// Periodic PmodJSTK2 transaction sequencer: one slot per tick, poll or host command,
// with SPI handshake timeout, frame capture, sticky timeout flag and overrun counter.
module jstk_poll_scheduler #(
    parameter int PERIOD_CYCLES  = 600000,
    parameter int TIMEOUT_CYCLES = 120000,
    parameter int CNT_W          = 20,
    parameter int DATA_W         = 40
) (
    input  logic                   CLK,
    input  logic                   RST,
    jstk_poll_scheduler_if.master  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_CAP   = 2'd3;

    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(TIMEOUT_CYCLES);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  per_q, per_d;
    logic [CNT_W-1:0]  to_q, to_d;
    logic              sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic [7:0]        ovr_q, ovr_d;
    logic              tick, start, to_hit;
    logic [CNT_W-1:0]  to_inc;

    always_comb begin
        per_d = '0;
        if (bus.EN) per_d = (per_q == PER_LAST) ? '0 : per_q + 1'b1;
        tick   = bus.EN && (per_q == PER_LAST);
        start  = (state_q == S_ISSUE) && !bus.SPI_BUSY;
        // >= rather than == since a long BUSY stall in ISSUE can carry the count past the limit
        to_hit = (state_q == S_WAIT) && !bus.SPI_DONE && (to_q >= TO_LAST);
        to_inc = (to_q == TO_MAX) ? to_q : to_q + 1'b1;

        state_d = state_q;
        to_d    = to_q;
        sel_d   = sel_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_ISSUE;
                    to_d    = '0;
                end
            end
            S_ISSUE: begin
                to_d = to_inc;
                if (start) begin
                    state_d = S_WAIT;
                    sel_d   = bus.CMD_VALID;
                end
            end
            S_WAIT: begin
                to_d = to_inc;
                if (bus.SPI_DONE) begin
                    state_d = S_CAP;
                    data_d  = bus.SPI_RX;
                end else if (to_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_CAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Clear first, then apply this cycle's events so a coinciding set survives.
        err_d = (err_q && !bus.ERR_CLR) || to_hit;
        ovr_d = bus.ERR_CLR ? 8'd0 : ovr_q;
        if (tick && (state_q != S_IDLE) && (ovr_d != 8'hFF)) ovr_d = ovr_d + 8'd1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            per_q   <= '0;
            to_q    <= '0;
            sel_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            ovr_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            to_q    <= to_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.SPI_START   = start;
    assign bus.CMD_READY   = start && bus.CMD_VALID;
    assign bus.SPI_SEL     = (state_q == S_ISSUE) ? bus.CMD_VALID :
                             ((state_q == S_WAIT) || (state_q == S_CAP)) ? sel_q : 1'b0;
    assign bus.DATA_OUT    = data_q;
    assign bus.DATA_VALID  = (state_q == S_CAP);
    assign bus.TIMEOUT_ERR = err_q;
    assign bus.OVERRUN_CNT = ovr_q;
endmodule

// File: tb/tb_jstk_poll_scheduler.sv
// Bench for jstk_poll_scheduler: two instances (timeout 30 and 200 cycles, period 100),
// directed stimulus, a cycle-level reference model and literal spot checks.
module tb_jstk_poll_scheduler;
    localparam int PER   = 100;
    localparam int TO_A  = 30;
    localparam int TO_B  = 200;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc = cyc + 1;

    int total = 0;
    int bad   = 0;

    logic        en [2], cmd_valid [2], busy [2], done [2], err_clr [2], man_done [2];
    logic [39:0] rx [2];
    logic        start [2], sel [2], ready [2], dv [2], terr [2];
    logic [39:0] dout [2];
    logic [7:0]  ovr [2];
    int          delay [2];

    jstk_poll_scheduler_if #(.DATA_W(40)) if_a ();
    jstk_poll_scheduler_if #(.DATA_W(40)) if_b ();

    jstk_poll_scheduler #(.PERIOD_CYCLES(PER), .TIMEOUT_CYCLES(TO_A), .CNT_W(20), .DATA_W(40))
        u_a (.CLK(CLK), .RST(RST), .bus(if_a));
    jstk_poll_scheduler #(.PERIOD_CYCLES(PER), .TIMEOUT_CYCLES(TO_B), .CNT_W(20), .DATA_W(40))
        u_b (.CLK(CLK), .RST(RST), .bus(if_b));

    assign if_a.EN = en[0];        assign if_b.EN = en[1];
    assign if_a.CMD_VALID = cmd_valid[0]; assign if_b.CMD_VALID = cmd_valid[1];
    assign if_a.SPI_BUSY = busy[0];  assign if_b.SPI_BUSY = busy[1];
    assign if_a.SPI_DONE = done[0];  assign if_b.SPI_DONE = done[1];
    assign if_a.SPI_RX = rx[0];      assign if_b.SPI_RX = rx[1];
    assign if_a.ERR_CLR = err_clr[0]; assign if_b.ERR_CLR = err_clr[1];

    assign start = '{if_a.SPI_START,   if_b.SPI_START};
    assign sel   = '{if_a.SPI_SEL,     if_b.SPI_SEL};
    assign ready = '{if_a.CMD_READY,   if_b.CMD_READY};
    assign dv    = '{if_a.DATA_VALID,  if_b.DATA_VALID};
    assign terr  = '{if_a.TIMEOUT_ERR, if_b.TIMEOUT_ERR};
    assign dout  = '{if_a.DATA_OUT,    if_b.DATA_OUT};
    assign ovr   = '{if_a.OVERRUN_CNT, if_b.OVERRUN_CNT};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_start(input int i, input int lim, output int s);
        s = -1;
        for (int k = 0; k < lim; k++) begin
            @(negedge CLK);
            if (start[i] === 1'b1) begin
                s = cyc;
                break;
            end
        end
        if (s < 0) begin
            total++;
            bad++;
            $display("FAIL wait_start dut%0d: no SPI_START within %0d cycles", i, lim);
        end
    endtask

    // SPI slave stand-in: DONE 'delay' cycles after each START (never when delay==0)
    initial begin
        bit pend [2];
        int due [2];
        pend = '{0, 0};
        due  = '{0, 0};
        done = '{1'b0, 1'b0};
        forever begin
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                if (!RST) pend[i] = 0;
                else if (start[i] === 1'b1 && delay[i] > 0) begin
                    pend[i] = 1;
                    due[i]  = cyc + delay[i];
                end
            end
            @(posedge CLK);
            #2;
            for (int i = 0; i < 2; i++) begin
                done[i] = man_done[i] || (pend[i] && cyc == due[i]);
                if (pend[i] && cyc == due[i]) pend[i] = 0;
            end
        end
    end

    // Reference model: slot timing from cycle numbers, one in-flight transaction per instance.
    bit          m_act [2], m_started [2], m_cap [2], m_sel [2], m_err [2];
    logic [39:0] m_data [2];
    int          m_issue [2], m_run [2], m_ovr [2];

    always @(negedge CLK) begin
        bit tick, e_start, wst, done_ev, to_ev, drop, acc;
        int to_c;
        for (int i = 0; i < 2; i++) begin
            to_c = (i == 0) ? TO_A : TO_B;
            if (!RST) begin
                m_act[i] = 0; m_started[i] = 0; m_cap[i] = 0; m_sel[i] = 0; m_err[i] = 0;
                m_data[i] = '0; m_issue[i] = 0; m_run[i] = 0; m_ovr[i] = 0;
                chk($sformatf("rst_start%0d", i), start[i], 0);
                chk($sformatf("rst_sel%0d", i), sel[i], 0);
                chk($sformatf("rst_ready%0d", i), ready[i], 0);
                chk($sformatf("rst_dv%0d", i), dv[i], 0);
                chk($sformatf("rst_dout%0d", i), dout[i], 0);
                chk($sformatf("rst_terr%0d", i), terr[i], 0);
                chk($sformatf("rst_ovr%0d", i), ovr[i], 0);
            end else begin
                tick    = en[i] && (m_run[i] % PER == PER - 1);
                e_start = m_act[i] && !m_started[i] && !busy[i];
                chk($sformatf("start%0d", i), start[i], e_start);
                chk($sformatf("ready%0d", i), ready[i], e_start && cmd_valid[i]);
                chk($sformatf("dv%0d", i), dv[i], m_cap[i]);
                chk($sformatf("dout%0d", i), dout[i], m_data[i]);
                chk($sformatf("terr%0d", i), terr[i], m_err[i]);
                chk($sformatf("ovr%0d", i), ovr[i], m_ovr[i]);
                if (e_start) chk($sformatf("sel_at_start%0d", i), sel[i], cmd_valid[i]);
                else if ((m_act[i] && m_started[i]) || m_cap[i])
                    chk($sformatf("sel_held%0d", i), sel[i], m_sel[i]);

                wst     = m_act[i] && m_started[i];
                done_ev = wst && done[i];
                to_ev   = wst && !done[i] && (cyc - m_issue[i] >= to_c - 1);
                drop    = tick && (m_act[i] || m_cap[i]);
                acc     = tick && !m_act[i] && !m_cap[i];
                if (e_start) begin
                    m_started[i] = 1;
                    m_sel[i]     = cmd_valid[i];
                end
                if (done_ev) begin
                    m_data[i] = rx[i];
                    m_act[i]  = 0;
                end
                if (to_ev) m_act[i] = 0;
                m_cap[i] = done_ev;
                if (acc) begin
                    m_act[i]     = 1;
                    m_started[i] = 0;
                    m_issue[i]   = cyc + 1;
                end
                if (err_clr[i]) begin
                    m_err[i] = 0;
                    m_ovr[i] = 0;
                end
                if (to_ev) m_err[i] = 1;
                if (drop && m_ovr[i] < 255) m_ovr[i] = m_ovr[i] + 1;
                m_run[i] = en[i] ? m_run[i] + 1 : 0;
            end
        end
    end

    initial begin
        int e0, e2, e3, s, rr, t, cur;
        en = '{1'b0, 1'b0}; cmd_valid = '{1'b0, 1'b0}; busy = '{1'b0, 1'b0};
        err_clr = '{1'b0, 1'b0}; man_done = '{1'b0, 1'b0};
        rx = '{40'h0, 40'h0}; delay = '{0, 0};

        step(3);
        @(negedge CLK);
        chk("reset_start", start[0], 0);
        chk("reset_dout", dout[0], 0);
        chk("reset_ovr_b", ovr[1], 0);
        step(1);
        RST = 1'b1;
        step(2);

        // 1: periodic polls
        delay[0] = 5;
        rx[0]    = 40'h12_3456_789A;
        en[0]    = 1'b1;
        e0       = cyc;
        for (int k = 1; k <= 3; k++) begin
            wait_start(0, 150, s);
            chk($sformatf("t1_start_%0d", k), s - e0, 100 * k);
            chk($sformatf("t1_sel_%0d", k), sel[0], 0);
        end
        repeat (6) @(negedge CLK);
        chk("t1_dv", dv[0], 1);
        chk("t1_dout", dout[0], 40'h12_3456_789A);

        // 2: host command takes the slot
        step(1);
        cmd_valid[0] = 1'b1;
        rx[0]        = 40'hA5_5A0F_F0C3;
        wait_start(0, 150, s);
        chk("t2_start", s - e0, 400);
        chk("t2_ready", ready[0], 1);
        chk("t2_sel", sel[0], 1);
        step(1);
        cmd_valid[0] = 1'b0;
        repeat (5) @(negedge CLK);
        chk("t2_sel_wait", sel[0], 1);
        @(negedge CLK);
        chk("t2_dv", dv[0], 1);
        chk("t2_dout", dout[0], 40'hA5_5A0F_F0C3);
        chk("t2_sel_cap", sel[0], 1);
        wait_start(0, 150, s);
        chk("t2_next_start", s - e0, 500);
        chk("t2_next_ready", ready[0], 0);
        chk("t2_next_sel", sel[0], 0);

        // 3: no DONE -> timeout 30 cycles after entering ISSUE
        step(1);
        delay[0] = 0;
        wait_start(0, 150, s);
        chk("t3_start", s - e0, 600);
        repeat (29) @(negedge CLK);
        chk("t3_terr_before", terr[0], 0);
        @(negedge CLK);
        chk("t3_terr", terr[0], 1);
        chk("t3_no_dv", dv[0], 0);
        step(1);
        delay[0] = 5;
        wait_start(0, 150, s);
        chk("t3_next_start", s - e0, 700);
        repeat (6) @(negedge CLK);
        chk("t3_next_dv", dv[0], 1);

        // 5: ERR_CLR alone, then coinciding with a timeout
        step(1);
        err_clr[0] = 1'b1;
        step(1);
        err_clr[0] = 1'b0;
        @(negedge CLK);
        chk("t5_clr_alone", terr[0], 0);
        step(1);
        delay[0] = 0;
        wait_start(0, 150, s);
        chk("t5_start", s - e0, 800);
        repeat (28) @(negedge CLK);
        step(1);
        err_clr[0] = 1'b1;
        step(1);
        err_clr[0] = 1'b0;
        @(negedge CLK);
        chk("t5_set_wins", terr[0], 1);
        step(1);
        err_clr[0] = 1'b1;
        step(1);
        err_clr[0] = 1'b0;
        @(negedge CLK);
        chk("t5_clr_terr", terr[0], 0);
        chk("t5_clr_ovr", ovr[0], 0);
        step(1);
        en[0] = 1'b0;

        // 4: long DONE on the 200-cycle instance -> one dropped tick, then saturation
        step(1);
        delay[1] = 150;
        rx[1]    = 40'h01_0203_0405;
        en[1]    = 1'b1;
        e2       = cyc;
        wait_start(1, 150, s);
        chk("t4_start", s - e2, 100);
        repeat (151) @(negedge CLK);
        chk("t4_dv", dv[1], 1);
        chk("t4_dout", dout[1], 40'h01_0203_0405);
        @(negedge CLK);
        chk("t4_ovr_one", ovr[1], 1);
        chk("t4_no_terr", terr[1], 0);
        step(1);
        delay[1] = 0;
        step(45000);
        @(negedge CLK);
        chk("t4_ovr_sat", ovr[1], 255);
        step(1);
        cur = cyc;
        t   = e2 + 399;
        while (t < cur + 2) t = t + 300;
        step(t - cur);
        err_clr[1] = 1'b1;
        step(1);
        err_clr[1] = 1'b0;
        @(negedge CLK);
        chk("t4_clr_with_drop", ovr[1], 1);
        chk("t4_clr_terr", terr[1], 0);
        step(1);
        err_clr[1] = 1'b1;
        step(1);
        err_clr[1] = 1'b0;
        @(negedge CLK);
        chk("t4_clr_ovr", ovr[1], 0);
        chk("t4_clr_terr2", terr[1], 0);

        // 6: async reset in WAIT_DONE, late DONE ignored
        step(1);
        en[0] = 1'b1;
        e3    = cyc;
        wait_start(0, 150, s);
        chk("t6_start", s - e3, 100);
        repeat (3) @(negedge CLK);
        #2;
        RST = 1'b0;
        #1;
        chk("t6_rst_start", start[0], 0);
        chk("t6_rst_sel", sel[0], 0);
        chk("t6_rst_ready", ready[0], 0);
        chk("t6_rst_dv", dv[0], 0);
        chk("t6_rst_dout", dout[0], 0);
        chk("t6_rst_terr", terr[0], 0);
        chk("t6_rst_ovr", ovr[0], 0);
        step(2);
        RST = 1'b1;
        rr  = cyc;
        step(2);
        man_done[0] = 1'b1;
        step(1);
        man_done[0] = 1'b0;
        @(negedge CLK);
        chk("t6_late_done_dv", dv[0], 0);
        wait_start(0, 150, s);
        chk("t6_restart", s - rr, 100);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
